// File: rtl/fetch_hazard_controller_pkg.sv
// Shared definitions for the fetch hazard controller: FSM encodings, hazard actions and
// default widths.
package fetch_hazard_controller_pkg;

  localparam int unsigned DefRegAw    = 5;
  localparam int unsigned DefCntWidth = 16;
  localparam int unsigned ZeroReg     = 0;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t StHold    = 2'd0;
  localparam fsm_state_t StRun     = 2'd1;
  localparam fsm_state_t StMemWait = 2'd2;

  typedef enum logic [1:0] {
    ActNone,
    ActLoadUse,
    ActMemWait,
    ActRedirect
  } hazard_action_e;

endpackage

// File: rtl/fetch_hazard_controller_load_use_detector.sv
// Flags a decode instruction that reads the destination of a load currently in EX.
module fetch_hazard_controller_load_use_detector
  import fetch_hazard_controller_pkg::*;
#(
  parameter int unsigned REG_AW = DefRegAw
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_usesRs,
  input  logic              id_usesRt,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  always_comb begin
    hazard = ex_memRead && (ex_rd != REG_AW'(ZeroReg)) &&
             ((id_usesRs && (id_rs == ex_rd)) || (id_usesRt && (id_rt == ex_rd)));
  end

endmodule

// File: rtl/fetch_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: branch redirects, load-use bubbles,
// data-memory waits and post-reset warm-up.
module fetch_hazard_controller
  import fetch_hazard_controller_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned CNT_WIDTH         = DefCntWidth,
  parameter int unsigned REG_AW            = DefRegAw
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic                 id_usesRs,
  input  logic                 id_usesRt,
  input  logic                 ex_memRead,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic                 mem_shouldBranch,
  input  logic [31:0]          mem_branchPc,
  input  logic                 dmem_busy,
  output logic                 pc_write,
  output logic                 if_shouldBranch,
  output logic [31:0]          if_branchPc,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 back_stall,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  localparam int unsigned HoldW =
      (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
  localparam fsm_state_t ResetState = (RESET_HOLD_CYCLES == 0) ? StRun : StHold;

  fsm_state_t           fsm_q, fsm_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 pending_q, pending_d;
  logic [31:0]          pending_pc_q, pending_pc_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;
  logic                 load_use;
  hazard_action_e       action;

  fetch_hazard_controller_load_use_detector #(
    .REG_AW(REG_AW)
  ) u_load_use_detector (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_usesRs  (id_usesRs),
    .id_usesRt  (id_usesRt),
    .ex_memRead (ex_memRead),
    .ex_rd      (ex_rd),
    .hazard     (load_use)
  );

  // Strict priority; a pending redirect only fires once memory is ready.
  always_comb begin
    action = ActNone;
    if (fsm_q != StHold) begin
      if (!dmem_busy && (mem_shouldBranch || pending_q)) begin
        action = ActRedirect;
      end else if (dmem_busy) begin
        action = ActMemWait;
      end else if (load_use) begin
        action = ActLoadUse;
      end
    end
  end

  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    exmem_flush     = 1'b0;
    back_stall      = 1'b0;
    if_shouldBranch = 1'b0;
    if_branchPc     = pending_q ? pending_pc_q : mem_branchPc;
    if (fsm_q == StHold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      unique case (action)
        ActRedirect: begin
          if_shouldBranch = 1'b1;
          ifid_flush      = 1'b1;
          idex_flush      = 1'b1;
          exmem_flush     = 1'b1;
        end
        ActMemWait: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          back_stall = 1'b1;
        end
        ActLoadUse: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
        ActNone: ;
      endcase
    end
  end

  always_comb begin
    fsm_d            = fsm_q;
    hold_cnt_d       = hold_cnt_q;
    pending_d        = pending_q;
    pending_pc_d     = pending_pc_q;
    stall_count_d    = stall_count_q;
    redirect_count_d = redirect_count_q;
    if (fsm_q == StHold) begin
      if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HoldW'(1);
      if (hold_cnt_q <= HoldW'(1)) fsm_d = StRun;
    end else begin
      fsm_d = (action == ActMemWait) ? StMemWait : StRun;
      // First branch captured during a wait wins.
      if (action == ActMemWait && mem_shouldBranch && !pending_q) begin
        pending_d    = 1'b1;
        pending_pc_d = mem_branchPc;
      end
      if (action == ActRedirect) pending_d = 1'b0;
    end
    if ((action == ActMemWait || action == ActLoadUse) && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
    if (action == ActRedirect && redirect_count_q != '1) begin
      redirect_count_d = redirect_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q            <= ResetState;
      hold_cnt_q       <= HoldW'(RESET_HOLD_CYCLES);
      pending_q        <= 1'b0;
      pending_pc_q     <= '0;
      stall_count_q    <= '0;
      redirect_count_q <= '0;
    end else begin
      fsm_q            <= fsm_d;
      hold_cnt_q       <= hold_cnt_d;
      pending_q        <= pending_d;
      pending_pc_q     <= pending_pc_d;
      stall_count_q    <= stall_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_count    = stall_count_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed bench for fetch_hazard_controller; a second instance with 4-bit counters
// shares the stimulus for the saturation check.
module tb_fetch_hazard_controller;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_usesRs, id_usesRt, ex_memRead;
  logic        mem_shouldBranch, dmem_busy;
  logic [31:0] mem_branchPc;

  logic        pc_write, if_shouldBranch, ifid_write, ifid_flush, idex_flush;
  logic        exmem_flush, back_stall;
  logic [31:0] if_branchPc;
  logic [15:0] stall_count, redirect_count;

  logic        s_pc_write, s_if_shouldBranch, s_ifid_write, s_ifid_flush, s_idex_flush;
  logic        s_exmem_flush, s_back_stall;
  logic [31:0] s_if_branchPc;
  logic [3:0]  s_stall_count, s_redirect_count;

  int n_checks = 0;
  int n_bad    = 0;

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, back_stall, if_shouldBranch}
  wire [6:0] ctl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, back_stall,
                    if_shouldBranch};
  localparam logic [6:0] CtlHold    = 7'b0011100;
  localparam logic [6:0] CtlRun     = 7'b1100000;
  localparam logic [6:0] CtlLoadUse = 7'b0001000;
  localparam logic [6:0] CtlMemWait = 7'b0000010;
  localparam logic [6:0] CtlRedir   = 7'b1111101;

  fetch_hazard_controller #(
    .RESET_HOLD_CYCLES(2),
    .CNT_WIDTH        (16),
    .REG_AW           (5)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_usesRs        (id_usesRs),
    .id_usesRt        (id_usesRt),
    .ex_memRead       (ex_memRead),
    .ex_rd            (ex_rd),
    .mem_shouldBranch (mem_shouldBranch),
    .mem_branchPc     (mem_branchPc),
    .dmem_busy        (dmem_busy),
    .pc_write         (pc_write),
    .if_shouldBranch  (if_shouldBranch),
    .if_branchPc      (if_branchPc),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .back_stall       (back_stall),
    .stall_count      (stall_count),
    .redirect_count   (redirect_count)
  );

  fetch_hazard_controller #(
    .RESET_HOLD_CYCLES(2),
    .CNT_WIDTH        (4),
    .REG_AW           (5)
  ) dut_small (
    .clock            (clock),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_usesRs        (id_usesRs),
    .id_usesRt        (id_usesRt),
    .ex_memRead       (ex_memRead),
    .ex_rd            (ex_rd),
    .mem_shouldBranch (mem_shouldBranch),
    .mem_branchPc     (mem_branchPc),
    .dmem_busy        (dmem_busy),
    .pc_write         (s_pc_write),
    .if_shouldBranch  (s_if_shouldBranch),
    .if_branchPc      (s_if_branchPc),
    .ifid_write       (s_ifid_write),
    .ifid_flush       (s_ifid_flush),
    .idex_flush       (s_idex_flush),
    .exmem_flush      (s_exmem_flush),
    .back_stall       (s_back_stall),
    .stall_count      (s_stall_count),
    .redirect_count   (s_redirect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_usesRs = 1'b0; id_usesRt = 1'b0;
    ex_memRead = 1'b0; ex_rd = '0;
    mem_shouldBranch = 1'b0; mem_branchPc = '0; dmem_busy = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #2;
    n_checks++;
    if (ctl !== CtlHold) begin
      n_bad++; $display("FAIL reset_hold0 ctl got=%b want=%b", ctl, CtlHold);
    end
    n_checks++;
    if (stall_count !== 16'd0 || redirect_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", stall_count, redirect_count);
    end
    step();
    // Inputs must be ignored while holding.
    mem_shouldBranch = 1'b1; mem_branchPc = 32'h44;
    #2;
    n_checks++;
    if (ctl !== CtlHold) begin
      n_bad++; $display("FAIL reset_hold1 ctl got=%b want=%b", ctl, CtlHold);
    end
    step();
    idle_inputs();
    #2;
    n_checks++;
    if (ctl !== CtlRun) begin
      n_bad++; $display("FAIL reset_run ctl got=%b want=%b", ctl, CtlRun);
    end
    n_checks++;
    if (redirect_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_hold_redirect got=%0d want=0", redirect_count);
    end
  endtask

  task automatic test_load_use();
    step();
    ex_memRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_usesRs = 1'b1;
    #2;
    n_checks++;
    if (ctl !== CtlLoadUse) begin
      n_bad++; $display("FAIL loaduse_rs ctl got=%b want=%b", ctl, CtlLoadUse);
    end
    step();
    ex_rd = 5'd0; id_rs = 5'd0;
    #2;
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_bad++; $display("FAIL loaduse_count got=%0d want=1", stall_count);
    end
    n_checks++;
    if (ctl !== CtlRun) begin
      n_bad++; $display("FAIL loaduse_rd0 ctl got=%b want=%b", ctl, CtlRun);
    end
    step();
    id_usesRs = 1'b0; id_rs = 5'd5; ex_rd = 5'd5;
    #2;
    n_checks++;
    if (ctl !== CtlRun) begin
      n_bad++; $display("FAIL loaduse_unused_rs ctl got=%b want=%b", ctl, CtlRun);
    end
    step();
    id_rs = 5'd0; id_usesRt = 1'b1; id_rt = 5'd5;
    #2;
    n_checks++;
    if (ctl !== CtlLoadUse) begin
      n_bad++; $display("FAIL loaduse_rt ctl got=%b want=%b", ctl, CtlLoadUse);
    end
    step();
    idle_inputs();
    #2;
    n_checks++;
    if (stall_count !== 16'd2) begin
      n_bad++; $display("FAIL loaduse_count2 got=%0d want=2", stall_count);
    end
  endtask

  task automatic test_redirect();
    step();
    ex_memRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_usesRs = 1'b1;
    mem_shouldBranch = 1'b1; mem_branchPc = 32'h40;
    #2;
    n_checks++;
    if (ctl !== CtlRedir) begin
      n_bad++; $display("FAIL redirect ctl got=%b want=%b", ctl, CtlRedir);
    end
    n_checks++;
    if (if_branchPc !== 32'h40) begin
      n_bad++; $display("FAIL redirect_pc got=%h want=%h", if_branchPc, 32'h40);
    end
    step();
    idle_inputs();
    #2;
    n_checks++;
    if (redirect_count !== 16'd1 || stall_count !== 16'd2) begin
      n_bad++;
      $display("FAIL redirect_counts got=%0d/%0d want=1/2", redirect_count, stall_count);
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] pcs [3];
    logic        brs [3];
    pcs[0] = 32'h80; pcs[1] = 32'hC0; pcs[2] = 32'h0;
    brs[0] = 1'b1;   brs[1] = 1'b1;   brs[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      dmem_busy = 1'b1; mem_shouldBranch = brs[i]; mem_branchPc = pcs[i];
      #2;
      n_checks++;
      if (ctl !== CtlMemWait) begin
        n_bad++; $display("FAIL memwait_%0d ctl got=%b want=%b", i, ctl, CtlMemWait);
      end
    end
    step();
    dmem_busy = 1'b0; mem_shouldBranch = 1'b0; mem_branchPc = 32'h1234;
    #2;
    n_checks++;
    if (ctl !== CtlRedir || if_branchPc !== 32'h80) begin
      n_bad++;
      $display("FAIL memwait_release ctl/pc got=%b/%h want=%b/%h", ctl, if_branchPc,
               CtlRedir, 32'h80);
    end
    step();
    #2;
    n_checks++;
    if (ctl !== CtlRun || if_branchPc !== 32'h1234) begin
      n_bad++;
      $display("FAIL memwait_cleared ctl/pc got=%b/%h want=%b/%h", ctl, if_branchPc,
               CtlRun, 32'h1234);
    end
    n_checks++;
    if (stall_count !== 16'd5 || redirect_count !== 16'd2) begin
      n_bad++;
      $display("FAIL memwait_counts got=%0d/%0d want=5/2", stall_count, redirect_count);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    step();
    dmem_busy = 1'b1; mem_shouldBranch = 1'b1; mem_branchPc = 32'h100;
    step();
    mem_shouldBranch = 1'b0;
    #2;
    n_checks++;
    if (ctl !== CtlMemWait) begin
      n_bad++; $display("FAIL midreset_wait ctl got=%b want=%b", ctl, CtlMemWait);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl !== CtlHold) begin
      n_bad++; $display("FAIL midreset_hold ctl got=%b want=%b", ctl, CtlHold);
    end
    n_checks++;
    if (stall_count !== 16'd0 || redirect_count !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset_counts got=%0d/%0d want=0/0", stall_count, redirect_count);
    end
    step();
    idle_inputs();
    reset = 1'b0;
    step(); step();
    #2;
    n_checks++;
    if (ctl !== CtlRun) begin
      n_bad++; $display("FAIL midreset_after ctl got=%b want=%b", ctl, CtlRun);
    end
    step();
    n_checks++;
    if (redirect_count !== 16'd0) begin
      n_bad++; $display("FAIL midreset_noredirect got=%0d want=0", redirect_count);
    end
  endtask

  task automatic test_saturation();
    ex_memRead = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_usesRt = 1'b1;
    for (int i = 0; i < 20; i++) step();
    idle_inputs();
    #2;
    n_checks++;
    if (s_stall_count !== 4'd15) begin
      n_bad++; $display("FAIL sat_small got=%0d want=15", s_stall_count);
    end
    n_checks++;
    if (stall_count !== 16'd20) begin
      n_bad++; $display("FAIL sat_wide got=%0d want=20", stall_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [2];
    pcs[0] = 32'h200; pcs[1] = 32'h204;
    for (int i = 0; i < 2; i++) begin
      step();
      mem_shouldBranch = 1'b1; mem_branchPc = pcs[i];
      #2;
      n_checks++;
      if (ctl !== CtlRedir || if_branchPc !== pcs[i]) begin
        n_bad++;
        $display("FAIL b2b_%0d ctl/pc got=%b/%h want=%b/%h", i, ctl, if_branchPc, CtlRedir,
                 pcs[i]);
      end
    end
    step();
    idle_inputs();
    #2;
    n_checks++;
    if (redirect_count !== 16'd2) begin
      n_bad++; $display("FAIL b2b_count got=%0d want=2", redirect_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_reset_mid_wait();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_hazard_controller.md
Name: fetch_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether the fetch stage's PC advances, redirects to a branch target, or holds, and which pipeline registers are frozen or flushed.
- Resolves MEM-stage branch redirects, decode load-use hazards, multi-cycle data-memory waits and post-reset warm-up.
- Sits beside the fetch stage and drives its PC-enable and branch-select inputs.

Parameters:
- RESET_HOLD_CYCLES, 2: cycles after reset with PC frozen and all stage registers flushed; 0 = run immediately.
- CNT_WIDTH, 16: width of the saturating performance counters.
- REG_AW, 5: register-file address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- id_rs  in  REG_AW  decode source register rs
- id_rt  in  REG_AW  decode source register rt
- id_usesRs  in  1  decode instruction reads rs
- id_usesRt  in  1  decode instruction reads rt
- ex_memRead  in  1  EX-stage instruction is a load
- ex_rd  in  REG_AW  EX-stage destination register
- mem_shouldBranch  in  1  branch taken, resolved in MEM
- mem_branchPc  in  32  branch target from MEM
- dmem_busy  in  1  data memory not ready; MEM result invalid this cycle
- pc_write  out  1  PC register update enable
- if_shouldBranch  out  1  fetch selects if_branchPc instead of pc+4
- if_branchPc  out  32  redirect target to fetch
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register loads a bubble
- idex_flush  out  1  ID/EX register loads a bubble
- exmem_flush  out  1  EX/MEM register loads a bubble
- back_stall  out  1  freezes ID/EX, EX/MEM, MEM/WB
- stall_count  out  CNT_WIDTH  stall cycles (load-use plus memory wait)
- redirect_count  out  CNT_WIDTH  branch redirects applied

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- Registered state: fsm, hold counter, pending flag, pending_pc, both counters. All outputs are combinational from that state and the current inputs.
- FSM states: HOLD, RUN, MEM_WAIT.
- Reset (asynchronous, also mid-operation): fsm=HOLD (RUN if RESET_HOLD_CYCLES=0), hold counter=RESET_HOLD_CYCLES, pending=0, pending_pc=0, counters=0.
- HOLD outputs: pc_write=0, ifid_write=0, ifid_flush=idex_flush=exmem_flush=1, back_stall=0, if_shouldBranch=0.
- HOLD timing: counter decrements each clock; leaves for RUN on the edge where it equals 1. RUN is entered exactly RESET_HOLD_CYCLES edges after reset deasserts. Inputs are ignored in HOLD.
- Default outputs outside HOLD: pc_write=1, ifid_write=1, all flushes 0, back_stall=0, if_shouldBranch=0, if_branchPc=mem_branchPc.
- RUN priority is strict, highest first:
  1. Redirect (mem_shouldBranch=1, dmem_busy=0): if_shouldBranch=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1. Load-use is ignored. redirect_count+1.
  2. Memory wait (dmem_busy=1): pc_write=0, ifid_write=0, back_stall=1, no flushes. If mem_shouldBranch=1, latch pending=1 and pending_pc=mem_branchPc. Go to MEM_WAIT. stall_count+1.
  3. Load-use (ex_memRead=1, ex_rd!=0, and either id_usesRs with id_rs==ex_rd or id_usesRt with id_rt==ex_rd): pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble. stall_count+1.
  4. Otherwise: defaults.
- MEM_WAIT with dmem_busy=1: same outputs as RUN case 2. The first captured branch wins; later mem_shouldBranch pulses do not overwrite pending_pc. stall_count+1 per cycle.
- MEM_WAIT with dmem_busy=0: the cycle is evaluated as RUN, except a redirect also fires when pending=1. In that case if_branchPc=pending_pc, not mem_branchPc. Clear pending; go to RUN.
- ex_rd==0 never causes a load-use stall.
- Counters saturate at all-ones and never wrap.
- A redirect counts as one event regardless of how many cycles it was pending.

Decomposition:
- Shared pipeline package holds:
  - the fsm state enum (HOLD, RUN, MEM_WAIT);
  - the REG_AW and CNT_WIDTH defaults;
  - the zero-register constant;
  - a hazard-action enum (NONE, LOADUSE, MEMWAIT, REDIRECT) used by the priority mux and for bench checking.
- Sub-module load_use_detector: purely combinational comparator producing a one-bit hazard. Everything else stays in the top block.

Test Plan:
- Reset, RESET_HOLD_CYCLES=2 -> pc_write=0 and all flushes 1 for exactly 2 cycles after deassert; third cycle pc_write=1, ifid_write=1, flushes 0.
- ex_memRead=1, ex_rd=8, id_rs=8, id_usesRs=1 -> one cycle pc_write=0, ifid_write=0, idex_flush=1, stall_count=1. Same stimulus with ex_rd=0 -> no stall.
- mem_shouldBranch=1, mem_branchPc=0x40, with a simultaneous load-use -> if_shouldBranch=1, if_branchPc=0x40, three flushes 1, idex-only bubble suppressed, redirect_count=1.
- dmem_busy high 3 cycles, with mem_shouldBranch=1 at 0x80 in the first cycle and 0xC0 in the second -> 3 cycles back_stall=1 and pc_write=0. Release cycle: redirect to 0x80, stall_count=3, redirect_count=1.
- Reset asserted mid-MEM_WAIT with pending=1 -> outputs immediately take HOLD values, pending cleared, counters 0; after hold, no redirect occurs.
- CNT_WIDTH=4, 20 consecutive load-use stalls -> stall_count holds 15.
